// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared types and constants for the shift register sequencer
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int SHIFT_W = 8;

endpackage

// File: rtl/shift_seq_cnt.sv
// rtl/shift_seq_cnt.sv - loadable down-counter tracking remaining shifts
module shift_seq_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero,
    output logic             last
);

    logic [CNT_W-1:0] count;

    // load wins over decrement; never wraps below zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);
    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - command-driven sequencer for the serial shift register (optional SHIFT_SEQ_HOLD_EN)
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = SHIFT_W,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SHIFT_SEQ_HOLD_EN
    input  logic             hold,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             sr_en,
    output logic             sr_lr,
    output logic             sr_si,
    input  logic             sr_sol,
    input  logic             sr_sor,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] tx;
    logic [WIDTH-1:0] rx;
    logic             dir;
    logic             stall;
    logic             accept;
    logic             shift_go;
    logic [CNT_W-1:0] len_clamped;
    logic             cnt_zero;
    logic             cnt_last;

`ifdef SHIFT_SEQ_HOLD_EN
    assign stall = hold;
`else
    assign stall = 1'b0;
`endif

    // oversized lengths saturate at the register width
    assign len_clamped = (cmd_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_len;

    shift_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (len_clamped),
        .dec      (shift_go),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next state and all handshake/datapath outputs; datapath pins idle low outside SHIFT
    always_comb begin
        state_n   = state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        sr_en     = 1'b0;
        sr_lr     = 1'b0;
        sr_si     = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        accept    = 1'b0;
        shift_go  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                accept    = cmd_valid;
                if (cmd_valid) begin
                    state_n = (len_clamped == '0) ? RESP : SHIFT;
                end
            end
            SHIFT: begin
                sr_lr    = dir;
                sr_si    = (dir == DIR_RIGHT) ? tx[0] : tx[WIDTH-1];
                // zero count here is unreachable; guard keeps a stray pulse off the datapath
                shift_go = !stall && !cnt_zero;
                sr_en    = shift_go;
                if (cnt_zero || (shift_go && cnt_last)) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = rx;
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // shift word out and capture pre-shift serial-out bits on the same edge the datapath moves
    always_ff @(posedge clk) begin
        if (rst) begin
            tx  <= '0;
            rx  <= '0;
            dir <= DIR_LEFT;
        end else if (accept) begin
            tx  <= cmd_data;
            rx  <= '0;
            dir <= cmd_dir;
        end else if (shift_go) begin
            if (dir == DIR_RIGHT) begin
                tx <= tx >> 1;
                rx <= {sr_sor, rx[WIDTH-1:1]};
            end else begin
                tx <= tx << 1;
                rx <= {rx[WIDTH-2:0], sr_sol};
            end
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl with a behavioural shift register
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_dir = 1'b0;
    logic [3:0] cmd_len = 4'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       sr_en;
    logic       sr_lr;
    logic       sr_si;
    logic       sr_sol;
    logic       sr_sor;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       busy;

    logic [7:0] dp;
    logic       preset_req = 1'b0;
    logic [7:0] preset_val = 8'h00;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .sr_en     (sr_en),
        .sr_lr     (sr_lr),
        .sr_si     (sr_si),
        .sr_sol    (sr_sol),
        .sr_sor    (sr_sor),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // behavioural 8-bit bidirectional shift register
    always @(posedge clk) begin
        if (preset_req) begin
            dp <= preset_val;
        end else if (sr_en) begin
            if (sr_lr) dp <= {sr_si, dp[7:1]};
            else       dp <= {dp[6:0], sr_si};
        end
    end
    assign sr_sol = dp[7];
    assign sr_sor = dp[0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       do_preset;
        logic [7:0] preset;
        logic       dir;
        logic [3:0] len;
        logic [7:0] data;
        logic [7:0] exp_rsp;
        logic [7:0] exp_dp;
        int         exp_en;
        logic [7:0] exp_seq;
    } vec_t;

    vec_t vecs[7];

    task automatic do_preset(input logic [7:0] v);
        @(negedge clk);
        preset_req = 1'b1;
        preset_val = v;
        @(negedge clk);
        preset_req = 1'b0;
    endtask

    task automatic wait_rsp(input string name, output int cyc);
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!rsp_valid) begin
            chk({name, "_rsp_timeout"}, 32'd0, 32'd1);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   cyc;
        int   en_cnt;
        int   bad;
        logic [7:0] seq;
        v = vecs[i];
        if (v.do_preset) do_preset(v.preset);
        @(negedge clk);
        chk($sformatf("v%0d_ready_idle", i), 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_dir   = v.dir;
        cmd_len   = v.len;
        cmd_data  = v.data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc    = 1;
        en_cnt = 0;
        bad    = 0;
        seq    = 8'h00;
        while (!rsp_valid && cyc < 40) begin
            if (sr_en) begin
                en_cnt++;
                seq = {seq[6:0], sr_si};
                if (sr_lr !== v.dir) bad++;
            end
            if (cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("v%0d_latency", i), 32'(cyc), 32'(v.exp_en + 1));
        chk($sformatf("v%0d_en_cycles", i), 32'(en_cnt), 32'(v.exp_en));
        chk($sformatf("v%0d_si_seq", i), 32'(seq), 32'(v.exp_seq));
        chk($sformatf("v%0d_busy_ready_lr", i), 32'(bad), 32'd0);
        chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(v.exp_rsp));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk($sformatf("v%0d_datapath", i), 32'(dp), 32'(v.exp_dp));
        chk($sformatf("v%0d_post_idle", i), {30'd0, rsp_valid, cmd_ready}, 32'd1);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{1'b1, 8'h00, 1'b0, 4'd8,  8'hA5, 8'h00, 8'hA5, 8, 8'hA5};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 4'd8,  8'h3C, 8'hA5, 8'h3C, 8, 8'h3C};
        vecs[2] = '{1'b1, 8'hFF, 1'b0, 4'd3,  8'hA0, 8'h07, 8'hFD, 3, 8'h05};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 4'd0,  8'h55, 8'h00, 8'hFD, 0, 8'h00};
        vecs[4] = '{1'b1, 8'h0F, 1'b1, 4'd12, 8'h96, 8'h0F, 8'h96, 8, 8'h69};
        vecs[5] = '{1'b1, 8'hC3, 1'b1, 4'd4,  8'h0A, 8'h30, 8'hAC, 4, 8'h05};
        vecs[6] = '{1'b1, 8'h5A, 1'b0, 4'd5,  8'hF8, 8'h0B, 8'h5F, 5, 8'h1F};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs",
            {24'd0, cmd_ready, busy, sr_en, sr_lr, sr_si, rsp_valid, 2'd0}, {24'd0, 8'b1000_0000});
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // response back-pressure with a second command waiting
        do_preset(8'h81);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_len = 4'd2; cmd_data = 8'hC0;
        @(negedge clk);
        cmd_dir = 1'b1; cmd_len = 4'd1; cmd_data = 8'h01;
        wait_rsp("stall", cyc);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_hold%0d", k),
                {20'd0, rsp_data, rsp_valid, cmd_ready, sr_en, 1'b0},
                {20'd0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0});
            @(negedge clk);
        end
        chk("stall_dp", 32'(dp), 32'h07);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("stall_after_hs", {30'd0, cmd_ready, rsp_valid}, 32'd2);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("stall_second_accept", {30'd0, sr_en, cmd_ready}, 32'd2);
        wait_rsp("second", cyc);
        chk("second_rsp", 32'(rsp_data), 32'h80);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("second_dp", 32'(dp), 32'h83);

        // reset in the middle of a shift
        do_preset(8'h00);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_len = 4'd8; cmd_data = 8'hFF;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_outputs", {28'd0, sr_en, rsp_valid, cmd_ready, busy}, 32'd2);
        repeat (3) @(negedge clk);
        chk("rst_mid_dp", 32'(dp), 32'h03);
        chk("rst_mid_quiet", {30'd0, sr_en, rsp_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
